// File: rtl/eq_pkg.sv
// Shared equaliser definitions: widths, LMS controller states, coefficient bank type
// and the W-bit saturating clamp used by the adaptation datapath.
package eq_pkg;

    localparam int unsigned W        = 16;
    localparam int unsigned NTAPS    = 16;
    localparam int unsigned FRAC     = 14;
    localparam int unsigned MU_SHIFT = 6;
    localparam int unsigned ADDR_W   = $clog2(NTAPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic signed [W-1:0] coef_t;
    typedef coef_t coef_arr_t [NTAPS];

    // Clamp a W+1-bit signed value into the W-bit signed range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] v);
        logic signed [W-1:0] r;
        if (v[W] != v[W-1]) begin
            r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// One-tap LMS update: coef + round(err * x * 2^-(FRAC+MU_SHIFT)), saturated to W bits.
// Purely combinational; the controller time-multiplexes a single instance over taps.
module lms_tap_mac
    import eq_pkg::*;
(
    input  logic signed [W-1:0] coef,
    input  logic signed [W-1:0] err,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] coef_new
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned SH = FRAC + MU_SHIFT;
    localparam logic signed [PW-1:0] RND = PW'(longint'(1) <<< (SH - 1));

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] delta;
    logic signed [W:0]    sum;

    // Delta magnitude stays far below 2^W, so truncating it to W+1 bits is lossless.
    always_comb begin
        prod     = PW'(err) * PW'(x);
        delta    = (prod + RND) >>> SH;
        sum      = (W + 1)'(coef) + (W + 1)'(delta);
        coef_new = sat_w(sum);
    end

endmodule

// File: rtl/lms_coef_update.sv
// LMS coefficient engine: per accepted sample, adapts a shadow bank one tap per cycle
// and then commits the whole bank to the FIR in a single edge.
module lms_coef_update
    import eq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic signed [W-1:0]      xn,
    input  logic signed [W-1:0]      yn,
    input  logic signed [W-1:0]      dn,
    input  logic                     freeze,
    input  logic                     load_en,
    input  logic        [ADDR_W-1:0] load_addr,
    input  logic signed [W-1:0]      load_data,
    input  logic                     load_commit,
    output coef_arr_t                coef_out,
    output logic                     busy,
    output logic                     update_done,
    output logic                     overrun
);

    state_t              state;
    logic [ADDR_W-1:0]   k;
    logic signed [W-1:0] err;
    coef_arr_t           hist;
    coef_arr_t           shadow;

    logic signed [W:0]   diff_c;
    logic signed [W-1:0] mac_out_c;

    assign diff_c = (W + 1)'(dn) - (W + 1)'(yn);

    lms_tap_mac u_mac (
        .coef     (shadow[k]),
        .err      (err),
        .x        (hist[k]),
        .coef_new (mac_out_c)
    );

    // Controller: loads/commits and sample acceptance only in IDLE; UPD walks the taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            err         <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                hist[i]     <= '0;
                shadow[i]   <= '0;
                coef_out[i] <= '0;
            end
        end else begin
            update_done <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        shadow[load_addr] <= load_data;
                    end
                    // A same-cycle load is visible to the commit.
                    if (load_commit) begin
                        for (int i = 0; i < int'(NTAPS); i++) begin
                            coef_out[i] <= (load_en && load_addr == ADDR_W'(i)) ? load_data
                                                                                : shadow[i];
                        end
                    end
                    if (sample_valid) begin
                        hist[0] <= xn;
                        for (int i = 1; i < int'(NTAPS); i++) begin
                            hist[i] <= hist[i-1];
                        end
                        if (!freeze) begin
                            err   <= sat_w(diff_c);
                            k     <= '0;
                            busy  <= 1'b1;
                            state <= UPD;
                        end
                    end
                end
                UPD: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    shadow[k] <= mac_out_c;
                    if (k == ADDR_W'(NTAPS - 1)) begin
                        state <= COMMIT;
                    end else begin
                        k <= k + ADDR_W'(1);
                    end
                end
                COMMIT: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    for (int i = 0; i < int'(NTAPS); i++) begin
                        coef_out[i] <= shadow[i];
                    end
                    update_done <= 1'b1;
                    busy        <= 1'b0;
                    k           <= '0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
